jac_control_unit: RTL and testbench

Sequencing controller for the Jac1-8 8-bit datapath. It fetches 16-bit instructions from a synchronous program ROM and decodes them. It drives the combinational ALU and writes results into an internal eight-entry register file. It holds the 6-bit status register and resolves program-flow opcodes into program-counter updates. It sits between the program memory and the ALU and is the only writer of registers, status and PC.

---
 rtl/jac_pkg.sv | 55 +++++
 rtl/jac_control_unit_if.sv | 23 ++
 rtl/jac_regfile.sv | 35 +++
 rtl/jac_control_unit.sv | 133 +++++++++++++
 tb/tb_jac_control_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 datapath: widths, instruction fields, opcodes, status bits, FSM states.
package jac_pkg;
    localparam int DataWidth     = 8;
    localparam int AddrWidth     = 8;
    localparam int NumRegs       = 8;
    localparam int RegIdxWidth   = 3;
    localparam int InstrWidth    = 16;
    localparam int NumStatusBits = 6;
    localparam int OpcodeWidth   = 5;

    localparam int OpcodeMsb = 15;
    localparam int OpcodeLsb = 11;
    localparam int RdMsb     = 10;
    localparam int RdLsb     = 8;
    localparam int ParamMsb  = 7;
    localparam int ParamLsb  = 0;
    localparam int RsMsb     = 2;
    localparam int RsLsb     = 0;

    localparam int StCarry     = 0;
    localparam int StUnderflow = 1;
    localparam int StZero      = 2;
    localparam int StEqual     = 3;
    localparam int StGreater   = 4;
    localparam int StSmaller   = 5;

    localparam logic [OpcodeWidth-1:0] OpNop  = 5'd0;
    localparam logic [OpcodeWidth-1:0] OpAdd  = 5'd1;
    localparam logic [OpcodeWidth-1:0] OpSub  = 5'd2;
    localparam logic [OpcodeWidth-1:0] OpAnd  = 5'd3;
    localparam logic [OpcodeWidth-1:0] OpOr   = 5'd4;
    localparam logic [OpcodeWidth-1:0] OpNot  = 5'd5;
    localparam logic [OpcodeWidth-1:0] OpXor  = 5'd6;
    localparam logic [OpcodeWidth-1:0] OpShl  = 5'd7;
    localparam logic [OpcodeWidth-1:0] OpShr  = 5'd8;
    localparam logic [OpcodeWidth-1:0] OpVal  = 5'd9;
    localparam logic [OpcodeWidth-1:0] OpCmp  = 5'd10;
    localparam logic [OpcodeWidth-1:0] OpGoto = 5'd16;
    localparam logic [OpcodeWidth-1:0] OpIfz  = 5'd17;
    localparam logic [OpcodeWidth-1:0] OpIfnz = 5'd18;
    localparam logic [OpcodeWidth-1:0] OpIfeq = 5'd19;
    localparam logic [OpcodeWidth-1:0] OpIfst = 5'd20;
    localparam logic [OpcodeWidth-1:0] OpIfgt = 5'd21;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_TRAP    = 2'd3
    } state_e;

    function automatic logic is_reserved(input logic [OpcodeWidth-1:0] op);
        return ((op >= 5'd11) && (op <= 5'd15)) || (op >= 5'd22);
    endfunction
endpackage

// File: rtl/jac_control_unit_if.sv
// Program-ROM and ALU bus between the control unit (master) and memory/ALU (slave).
interface jac_control_unit_if;
    import jac_pkg::*;

    logic [AddrWidth-1:0]     instr_addr;
    logic [InstrWidth-1:0]    instr_data;
    logic [OpcodeWidth-1:0]   alu_opcode;
    logic [DataWidth-1:0]     alu_operand1;
    logic [DataWidth-1:0]     alu_operand2;
    logic [7:0]               alu_param;
    logic [DataWidth-1:0]     alu_result;
    logic [NumStatusBits-1:0] alu_status;

    modport master (
        output instr_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
        input  instr_data, alu_result, alu_status
    );

    modport slave (
        input  instr_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
        output instr_data, alu_result, alu_status
    );
endinterface

// File: rtl/jac_regfile.sv
// NumRegs x DataWidth register file: two combinational read ports, a debug read port,
// one synchronous write port, synchronous active-low clear.
module jac_regfile
    import jac_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [RegIdxWidth-1:0] wr_idx,
    input  logic [DataWidth-1:0]   wr_data,
    input  logic [RegIdxWidth-1:0] rd_idx_a,
    input  logic [RegIdxWidth-1:0] rd_idx_b,
    input  logic [RegIdxWidth-1:0] dbg_sel,
    output logic [DataWidth-1:0]   rd_data_a,
    output logic [DataWidth-1:0]   rd_data_b,
    output logic [DataWidth-1:0]   dbg_data
);
    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wr_idx] = wr_data;
    end

    // Clear wins over a same-edge write.
    always_ff @(posedge clock) begin
        if (!reset_n) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end

    assign rd_data_a = regs_q[rd_idx_a];
    assign rd_data_b = regs_q[rd_idx_b];
    assign dbg_data  = regs_q[dbg_sel];
endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 sequencer: FETCH/DECODE/EXECUTE, 3 cycles per instruction; run=0 pauses in FETCH.
// Macro JAC_CTRL_ILLEGAL_TRAP_EN: reserved opcodes trap (sticky illegal_op, TRAP until reset); else NOP.
module jac_control_unit
    import jac_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run,
    jac_control_unit_if.master       bus,
    output logic [NumStatusBits-1:0] status_reg,
    output logic                     illegal_op,
    input  logic [RegIdxWidth-1:0]   dbg_sel,
    output logic [DataWidth-1:0]     dbg_data
);
    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     pc_q, pc_d;
    logic [InstrWidth-1:0]    ir_q, ir_d;
    logic [NumStatusBits-1:0] status_q, status_d;

    logic                     wr_en;
    logic [DataWidth-1:0]     wr_data;
    logic [OpcodeWidth-1:0]   opcode;
    logic [RegIdxWidth-1:0]   rd_idx;
    logic [RegIdxWidth-1:0]   rs_idx;
    logic [7:0]               param;

    assign opcode = ir_q[OpcodeMsb:OpcodeLsb];
    assign rd_idx = ir_q[RdMsb:RdLsb];
    assign param  = ir_q[ParamMsb:ParamLsb];
    assign rs_idx = param[RsMsb:RsLsb];

`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    jac_regfile u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_idx    (rd_idx),
        .wr_data   (wr_data),
        .rd_idx_a  (rd_idx),
        .rd_idx_b  (rs_idx),
        .dbg_sel   (dbg_sel),
        .rd_data_a (bus.alu_operand1),
        .rd_data_b (bus.alu_operand2),
        .dbg_data  (dbg_data)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        status_d       = status_q;
        wr_en          = 1'b0;
        wr_data        = bus.alu_result;
        bus.alu_opcode = OpNop;
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
        illegal_d      = illegal_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (run) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = bus.instr_data;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                bus.alu_opcode = opcode;
                state_d        = ST_FETCH;
                pc_d           = pc_q + AddrWidth'(1);
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpNot, OpXor, OpShl, OpShr: begin
                        wr_en    = 1'b1;
                        status_d = bus.alu_status;
                    end
                    OpCmp:  status_d = bus.alu_status;
                    OpVal: begin
                        wr_en   = 1'b1;
                        wr_data = param;
                    end
                    OpGoto: pc_d = param;
                    OpIfz:  if (status_q[StZero])    pc_d = param;
                    OpIfnz: if (!status_q[StZero])   pc_d = param;
                    OpIfeq: if (status_q[StEqual])   pc_d = param;
                    OpIfst: if (status_q[StSmaller]) pc_d = param;
                    OpIfgt: if (status_q[StGreater]) pc_d = param;
                    default: begin
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
                        if (is_reserved(opcode)) begin
                            pc_d      = pc_q;
                            illegal_d = 1'b1;
                            state_d   = ST_TRAP;
                        end
`endif
                    end
                endcase
            end
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            status_q  <= '0;
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            status_q  <= status_d;
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.instr_addr = pc_q;
    assign bus.alu_param  = param;
    assign status_reg     = status_q;
endmodule

// File: tb/tb_jac_control_unit.sv
// Bench for jac_control_unit: behavioural ROM and ALU, instruction-level reference model,
// directed program from the test plan followed by a random program.
module tb_jac_control_unit;
    import jac_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b1;
    logic [2:0] dbg_sel = 3'd0;
    logic [5:0] status_reg;
    logic       illegal_op;
    logic [7:0] dbg_data;

    jac_control_unit_if bus ();

    jac_control_unit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .bus        (bus),
        .status_reg (status_reg),
        .illegal_op (illegal_op),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #20 clock = ~clock;

    logic [15:0] rom [256];
    always @(posedge clock) bus.instr_data <= rom[bus.instr_addr];

    // Behavioural ALU: returns {status, result}.
    function automatic logic [13:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        logic [5:0] s;
        wide = 9'd0;
        c    = 1'b0;
        case (op)
            5'd1:        begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8]; end
            5'd2, 5'd10: r = a - b;
            5'd3:        r = a & b;
            5'd4:        r = a | b;
            5'd5:        r = ~a;
            5'd6:        r = a ^ b;
            5'd7:        begin r = {a[6:0], 1'b0}; c = a[7]; end
            5'd8:        begin r = {1'b0, a[7:1]}; c = a[0]; end
            default:     r = 8'd0;
        endcase
        s    = 6'd0;
        s[0] = c;
        s[1] = ((op == 5'd2) || (op == 5'd10)) && (a < b);
        s[2] = (r == 8'd0);
        s[3] = (a == b);
        s[4] = (a > b);
        s[5] = (a < b);
        return {s, r};
    endfunction

    always_comb {bus.alu_status, bus.alu_result} = alu_f(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] m_regs [8];
    logic [5:0] m_status;
    logic [7:0] m_pc;

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] p);
        return {op, rd, p};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
        m_status = 6'd0;
        m_pc     = 8'd0;
    endtask

    // One whole instruction, architecturally.
    task automatic m_exec(input logic [15:0] w);
        logic [4:0]  op;
        logic [7:0]  p;
        logic [13:0] res;
        logic        take;
        op   = w[15:11];
        p    = w[7:0];
        res  = alu_f(op, m_regs[w[10:8]], m_regs[p[2:0]]);
        take = 1'b0;
        if (op >= 5'd1 && op <= 5'd8) begin
            m_regs[w[10:8]] = res[7:0];
            m_status        = res[13:8];
        end else if (op == 5'd10) m_status = res[13:8];
        else if (op == 5'd9)      m_regs[w[10:8]] = p;
        else if (op == 5'd16)     take = 1'b1;
        else if (op == 5'd17)     take = m_status[2];
        else if (op == 5'd18)     take = !m_status[2];
        else if (op == 5'd19)     take = m_status[3];
        else if (op == 5'd20)     take = m_status[5];
        else if (op == 5'd21)     take = m_status[4];
        m_pc = take ? p : m_pc + 8'd1;
    endtask

    task automatic check_arch();
        chk("pc", bus.instr_addr, m_pc);
        chk("status", status_reg, m_status);
        chk("illegal", illegal_op, 1'b0);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = i[2:0];
            #1;
            chk($sformatf("r%0d", i), dbg_data, m_regs[i]);
        end
    endtask

    task automatic rd_reg(input int i, output logic [7:0] v);
        dbg_sel = i[2:0];
        #1;
        v = dbg_data;
    endtask

    // Called at the falling edge of a FETCH cycle; returns at the next one.
    task automatic step();
        logic [15:0] w;
        w = rom[m_pc];
        chk("fetch_addr", bus.instr_addr, m_pc);
        chk("fetch_opc", bus.alu_opcode, 5'd0);
        @(posedge clock); @(negedge clock);
        chk("decode_addr", bus.instr_addr, m_pc);
        chk("decode_opc", bus.alu_opcode, 5'd0);
        @(posedge clock); @(negedge clock);
        chk("exec_opc", bus.alu_opcode, w[15:11]);
        chk("exec_op1", bus.alu_operand1, m_regs[w[10:8]]);
        chk("exec_op2", bus.alu_operand2, m_regs[w[2:0]]);
        chk("exec_param", bus.alu_param, w[7:0]);
        m_exec(w);
        @(posedge clock); @(negedge clock);
        check_arch();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        m_reset();
        chk("rst_opc", bus.alu_opcode, 5'd0);
        check_arch();
    endtask

    logic [4:0] valid_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                   5'd9, 5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};

    initial begin
        logic [7:0] v;
        logic [4:0] op;
        logic [7:0] trap_pc;

        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[8'h00] = ins(OpVal, 3'd0, 8'd200);
        rom[8'h01] = ins(OpVal, 3'd1, 8'd100);
        rom[8'h02] = ins(OpAdd, 3'd0, 8'd1);
        rom[8'h03] = ins(OpVal, 3'd2, 8'd5);
        rom[8'h04] = ins(OpVal, 3'd3, 8'd5);
        rom[8'h05] = ins(OpSub, 3'd2, 8'd3);
        rom[8'h06] = ins(OpIfz, 3'd0, 8'h40);
        rom[8'h40] = ins(OpVal, 3'd4, 8'd3);
        rom[8'h41] = ins(OpVal, 3'd5, 8'd9);
        rom[8'h42] = ins(OpCmp, 3'd4, 8'd5);
        rom[8'h43] = ins(OpIfgt, 3'd0, 8'h20);
        rom[8'h44] = ins(OpIfst, 3'd0, 8'h20);
        rom[8'h20] = ins(OpGoto, 3'd0, 8'hFF);
        rom[8'hFF] = ins(OpNop, 3'd0, 8'h00);

        @(negedge clock);
        do_reset();

        repeat (3) step();
        rd_reg(0, v);
        chk("add_r0", v, 8'd44);
        chk("add_status", status_reg, 6'h11);
        repeat (4) step();
        rd_reg(2, v);
        chk("sub_r2", v, 8'd0);
        chk("sub_status", status_reg, 6'h0C);
        chk("ifz_pc", bus.instr_addr, 8'h40);
        repeat (4) step();
        chk("ifgt_pc", bus.instr_addr, 8'h44);
        chk("cmp_status", status_reg, 6'h22);
        rd_reg(4, v);
        chk("cmp_r4", v, 8'd3);
        step();
        chk("ifst_pc", bus.instr_addr, 8'h20);
        step();
        chk("goto_pc", bus.instr_addr, 8'hFF);
        step();
        chk("wrap_pc", bus.instr_addr, 8'h00);

        // Pause: run drops during DECODE of VAL r0,200.
        rom[8'h02] = ins(OpVal, 3'd6, 8'h55);
        @(posedge clock); @(negedge clock);
        run = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("pause_exec_opc", bus.alu_opcode, OpVal);
        m_exec(rom[8'h00]);
        @(posedge clock);
        repeat (4) begin
            @(negedge clock);
            chk("pause_addr", bus.instr_addr, m_pc);
            chk("pause_opc", bus.alu_opcode, 5'd0);
        end
        rd_reg(0, v);
        chk("pause_r0", v, 8'd200);
        run = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("resume_decode_opc", bus.alu_opcode, 5'd0);
        @(posedge clock); @(negedge clock);
        chk("resume_exec_opc", bus.alu_opcode, OpVal);
        m_exec(rom[8'h01]);
        @(posedge clock); @(negedge clock);
        check_arch();

        // Reset lands on the EXECUTE edge of VAL r6,0x55.
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("rstx_exec_opc", bus.alu_opcode, OpVal);
        reset_n = 1'b0;
        @(posedge clock); @(negedge clock);
        rd_reg(6, v);
        chk("rstx_r6", v, 8'd0);
        chk("rstx_pc", bus.instr_addr, 8'd0);
        reset_n = 1'b1;
        m_reset();
        check_arch();

        // Random program.
        for (int a = 0; a < 256; a++) begin
            op = valid_ops[$urandom_range(0, 16)];
`ifndef JAC_CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0)
                op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(11, 15)) : 5'($urandom_range(22, 31));
`endif
            rom[a] = ins(op, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        do_reset();
        repeat (400) step();

        // Reserved opcode 11000.
        trap_pc = m_pc;
        rom[trap_pc] = ins(5'b11000, 3'd1, 8'h12);
`ifdef JAC_CTRL_ILLEGAL_TRAP_EN
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("trap_illegal", illegal_op, 1'b1);
        chk("trap_pc", bus.instr_addr, trap_pc);
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("trap_hold_pc", bus.instr_addr, trap_pc);
        chk("trap_hold_opc", bus.alu_opcode, 5'd0);
        chk("trap_hold_illegal", illegal_op, 1'b1);
        chk("trap_status", status_reg, m_status);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, v);
            chk($sformatf("trap_r%0d", i), v, m_regs[i]);
        end
        do_reset();
`else
        step();
        chk("rsv_pc", bus.instr_addr, trap_pc + 8'd1);
        chk("rsv_illegal", illegal_op, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
